// File: rtl/imem_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : imem_arb_pkg
// Brief   : Shared types and constants for the instruction-memory arbiter.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package imem_arb_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    typedef enum logic {
        REQ_FETCH  = 1'b0,
        REQ_LOADER = 1'b1
    } req_id_t;

    localparam logic [31:0] ERR_RDATA = 32'h0;

    // Word-aligned and inside the 2**aw word array.
    function automatic logic addr_bad(input logic [31:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : imem_arbiter_if
// Brief   : Fetch, loader, boot and memory-array signals of the arbiter.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface imem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;
    logic              f_err;
    logic              l_req;
    logic              l_we;
    logic              l_lock;
    logic [31:0]       l_addr;
    logic [31:0]       l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [31:0]       l_rdata;
    logic              l_err;
    logic              boot_done;
    logic              core_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, boot_done, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, l_err,
               core_stall, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, boot_done, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, l_err,
               core_stall, mem_addr, mem_we, mem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/imem_arbiter_rsp.sv
//------------------------------------------------------------------------------
// Module  : imem_arb_rsp
// Brief   : One-cycle response register (rvalid/rdata/err) for one requester.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_arb_rsp
    import imem_arb_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_gnt,
    input  wire logic        i_err,
    input  wire logic        i_we,
    input  wire logic [31:0] i_mem_rdata,
    output logic             o_rvalid,
    output logic [31:0]      o_rdata,
    output logic             o_err
);

    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= ERR_RDATA;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= i_gnt;
            r_err    <= i_gnt & i_err;
            // Writes and errored accesses return zero data.
            r_rdata  <= (i_gnt && !i_err && !i_we) ? i_mem_rdata : ERR_RDATA;
        end
    end

    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_err    = r_err;

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
//------------------------------------------------------------------------------
// Module  : imem_arbiter
// Brief   : Boot-sequenced, round-robin/lockable arbiter for the single-port
//           instruction memory. Optional perf counters: IMEM_ARB_PERF_EN.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int BOOT_BYPASS = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,
`ifdef IMEM_ARB_PERF_EN
    output logic [31:0]       perf_conflicts,
    output logic [31:0]       perf_fetch_stalls,
`endif
    imem_arbiter_if.slave     bus
);

    localparam state_t c_rst_state = (BOOT_BYPASS != 0) ? ST_RUN : ST_BOOT;

    state_t            r_state;
    state_t            w_state_nxt;
    req_id_t           r_rr_last;
    logic              r_fetch_pri;
    logic              w_f_gnt;
    logic              w_l_gnt;
    logic              w_f_err;
    logic              w_l_err;
    logic              w_core_stall;
    logic [ADDR_W-1:0] w_mem_addr;

    assign w_f_err = addr_bad(bus.f_addr, ADDR_W);
    assign w_l_err = addr_bad(bus.l_addr, ADDR_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_rst_state;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: if (bus.boot_done)             w_state_nxt = ST_RUN;
            ST_RUN:  if (w_l_gnt && bus.l_lock)     w_state_nxt = ST_LOCK;
            ST_LOCK: if (!bus.l_lock)               w_state_nxt = ST_RUN;
            default:                                w_state_nxt = c_rst_state;
        endcase
    end

    always_comb begin
        w_f_gnt = 1'b0;
        w_l_gnt = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.f_req && bus.l_req) begin
                    if (r_fetch_pri || (r_rr_last == REQ_LOADER)) w_f_gnt = 1'b1;
                    else                                          w_l_gnt = 1'b1;
                end else begin
                    w_f_gnt = bus.f_req;
                    w_l_gnt = bus.l_req;
                end
            end
            default: w_l_gnt = bus.l_req;
        endcase
        // No grant may escape while reset is asserted.
        if (!rst) begin
            w_f_gnt = 1'b0;
            w_l_gnt = 1'b0;
        end
        w_core_stall = (r_state != ST_RUN) | (bus.f_req & ~w_f_gnt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_last   <= REQ_FETCH;
            r_fetch_pri <= 1'b0;
        end else begin
            r_fetch_pri <= (r_state == ST_LOCK) && !bus.l_lock;
            if ((r_state == ST_RUN) && bus.f_req && bus.l_req)
                r_rr_last <= w_f_gnt ? REQ_FETCH : REQ_LOADER;
        end
    end

    assign w_mem_addr = w_l_gnt ? bus.l_addr[ADDR_W+1:2] :
                        w_f_gnt ? bus.f_addr[ADDR_W+1:2] : '0;

    assign bus.f_gnt      = w_f_gnt;
    assign bus.l_gnt      = w_l_gnt;
    assign bus.core_stall = w_core_stall;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_we     = w_l_gnt & bus.l_we & ~w_l_err;
    assign bus.mem_wdata  = bus.l_wdata;

    imem_arb_rsp u_rsp_f (
        .clk         (clk),
        .rst         (rst),
        .i_gnt       (w_f_gnt),
        .i_err       (w_f_err),
        .i_we        (1'b0),
        .i_mem_rdata (bus.mem_rdata),
        .o_rvalid    (bus.f_rvalid),
        .o_rdata     (bus.f_rdata),
        .o_err       (bus.f_err)
    );

    imem_arb_rsp u_rsp_l (
        .clk         (clk),
        .rst         (rst),
        .i_gnt       (w_l_gnt),
        .i_err       (w_l_err),
        .i_we        (bus.l_we),
        .i_mem_rdata (bus.mem_rdata),
        .o_rvalid    (bus.l_rvalid),
        .o_rdata     (bus.l_rdata),
        .o_err       (bus.l_err)
    );

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] r_perf_conflicts;
    logic [31:0] r_perf_fetch_stalls;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_conflicts    <= '0;
            r_perf_fetch_stalls <= '0;
        end else begin
            if (bus.f_req && bus.l_req && (r_perf_conflicts != '1))
                r_perf_conflicts <= r_perf_conflicts + 32'd1;
            if (w_core_stall && (r_state != ST_BOOT) && (r_perf_fetch_stalls != '1))
                r_perf_fetch_stalls <= r_perf_fetch_stalls + 32'd1;
        end
    end

    assign perf_conflicts    = r_perf_conflicts;
    assign perf_fetch_stalls = r_perf_fetch_stalls;
`else
    // Counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_imem_arbiter
// Brief   : Directed scoreboard bench for imem_arbiter (ADDR_W=10, boot mode).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_arbiter;

    localparam int ADDR_W = 10;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic        clk;
    logic        rst;
    int          total;
    int          bad;
    rsp_t        f_q[$];
    rsp_t        l_q[$];
    rsp_t        fe;
    rsp_t        le;
    logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
    logic [31:0] tb_mem  [0:(1<<ADDR_W)-1];

    imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_conflicts;
    logic [31:0] perf_fetch_stalls;
`endif

    imem_arbiter #(.ADDR_W(ADDR_W), .BOOT_BYPASS(0)) dut (
        .clk               (clk),
        .rst               (rst),
`ifdef IMEM_ARB_PERF_EN
        .perf_conflicts    (perf_conflicts),
        .perf_fetch_stalls (perf_fetch_stalls),
`endif
        .bus               (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    assign bus.mem_rdata = tb_mem[bus.mem_addr];

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: every pending expectation must retire on the next cycle.
    always @(posedge clk) begin
        #2;
        check("f_rvalid", {31'd0, bus.f_rvalid}, {31'd0, f_q.size() != 0});
        if (f_q.size() != 0) begin
            fe = f_q.pop_front();
            if (bus.f_rvalid) begin
                check("f_rdata", bus.f_rdata, fe.data);
                check("f_err", {31'd0, bus.f_err}, {31'd0, fe.err});
            end
        end
        check("l_rvalid", {31'd0, bus.l_rvalid}, {31'd0, l_q.size() != 0});
        if (l_q.size() != 0) begin
            le = l_q.pop_front();
            if (bus.l_rvalid) begin
                check("l_rdata", bus.l_rdata, le.data);
                check("l_err", {31'd0, bus.l_err}, {31'd0, le.err});
            end
        end
    end

    task automatic cyc(input string tag, input logic fr, input logic [31:0] fa,
                       input logic lr, input logic lw, input logic lk,
                       input logic [31:0] la, input logic [31:0] ld, input logic bd,
                       input logic efg, input logic elg, input logic ecs);
        rsp_t r;
        logic le_err;
        @(negedge clk);
        bus.f_req = fr;  bus.f_addr = fa;
        bus.l_req = lr;  bus.l_we = lw;  bus.l_lock = lk;
        bus.l_addr = la; bus.l_wdata = ld; bus.boot_done = bd;
        #1;
        le_err = bad_addr(la);
        check({tag, "_fgnt"}, {31'd0, bus.f_gnt}, {31'd0, efg});
        check({tag, "_lgnt"}, {31'd0, bus.l_gnt}, {31'd0, elg});
        check({tag, "_stall"}, {31'd0, bus.core_stall}, {31'd0, ecs});
        check({tag, "_mwe"}, {31'd0, bus.mem_we}, {31'd0, elg & lw & ~le_err});
        if (elg && !le_err) check({tag, "_maddr"}, {22'd0, bus.mem_addr}, {22'd0, la[ADDR_W+1:2]});
        if (efg) begin
            r.err  = bad_addr(fa);
            r.data = r.err ? 32'h0 : ref_mem[fa[ADDR_W+1:2]];
            f_q.push_back(r);
        end
        if (elg) begin
            r.err = le_err;
            if (le_err || lw) r.data = 32'h0;
            else              r.data = ref_mem[la[ADDR_W+1:2]];
            if (!le_err && lw) ref_mem[la[ADDR_W+1:2]] = ld;
            l_q.push_back(r);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = 32'h0;
        rst = 1'b0;
        bus.f_req = 0; bus.f_addr = 0; bus.l_req = 0; bus.l_we = 0; bus.l_lock = 0;
        bus.l_addr = 0; bus.l_wdata = 0; bus.boot_done = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_fgnt", {31'd0, bus.f_gnt}, 32'd0);
        check("rst_lgnt", {31'd0, bus.l_gnt}, 32'd0);
        check("rst_stall", {31'd0, bus.core_stall}, 32'd1);
        check("rst_mwe", {31'd0, bus.mem_we}, 32'd0);
        check("rst_maddr", {22'd0, bus.mem_addr}, 32'd0);
        check("rst_rdata", bus.f_rdata | bus.l_rdata, 32'd0);
        rst = 1'b1;

        // Boot load: fetch is refused until boot_done
        cyc("boot_w0", 1, 32'h0, 1, 1, 0, 32'h0, 32'h0062E233, 0, 0, 1, 1);
        cyc("boot_w1", 1, 32'h0, 1, 1, 0, 32'h4, 32'h00832383, 0, 0, 1, 1);
        cyc("boot_rd", 0, 32'h0, 1, 0, 1, 32'h4, 32'h0, 0, 0, 1, 1);
        cyc("boot_dn", 1, 32'h4, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 1);
        cyc("run_f4", 1, 32'h4, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0);

        // Contention: L,F,L,F
        cyc("rr0", 1, 32'h0, 1, 0, 0, 32'h4, 32'h0, 0, 0, 1, 1);
        cyc("rr1", 1, 32'h0, 1, 0, 0, 32'h4, 32'h0, 0, 1, 0, 0);
        cyc("rr2", 1, 32'h0, 1, 0, 0, 32'h4, 32'h0, 0, 0, 1, 1);
        cyc("rr3", 1, 32'h0, 1, 0, 0, 32'h4, 32'h0, 0, 1, 0, 0);

        // Lock burst, then fetch priority on the first RUN cycle
        cyc("lk0", 0, 32'h0, 1, 1, 1, 32'h10, 32'hA0A0_0001, 0, 0, 1, 0);
        cyc("lk1", 1, 32'h0, 1, 1, 1, 32'h14, 32'hA0A0_0002, 0, 0, 1, 1);
        cyc("lk2", 1, 32'h0, 1, 1, 1, 32'h18, 32'hA0A0_0003, 0, 0, 1, 1);
        cyc("lk_drop", 1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 1);
        cyc("lk_pri", 1, 32'h14, 1, 0, 0, 32'h18, 32'h0, 0, 1, 0, 0);
        cyc("lk_rr", 1, 32'h10, 1, 0, 0, 32'h18, 32'h0, 0, 0, 1, 1);

        // Errors
        cyc("err_f", 1, 32'h2, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0);
        cyc("err_l", 0, 32'h0, 1, 1, 0, 32'h1000, 32'hFFFF_FFFF, 0, 0, 1, 0);
        cyc("err_chk", 1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0);
        cyc("bd_ign", 1, 32'h10, 0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 0);
        cyc("bd_ign2", 1, 32'h18, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0);

        // Async reset between a grant and its response
        @(negedge clk);
        bus.f_req = 0; bus.l_req = 1; bus.l_we = 0; bus.l_lock = 0;
        bus.l_addr = 32'h4; bus.boot_done = 0;
        #1;
        check("ar_lgnt_pre", {31'd0, bus.l_gnt}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("ar_lgnt", {31'd0, bus.l_gnt}, 32'd0);
        check("ar_mwe", {31'd0, bus.mem_we}, 32'd0);
        check("ar_maddr", {22'd0, bus.mem_addr}, 32'd0);
        check("ar_stall", {31'd0, bus.core_stall}, 32'd1);
        check("ar_rvalid", {30'd0, bus.f_rvalid, bus.l_rvalid}, 32'd0);
        repeat (2) @(negedge clk);
        bus.l_req = 0;
        rst = 1'b1;
        cyc("ar_boot", 1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 1);

        // Five conflict cycles in BOOT: loader always wins
        for (int i = 0; i < 5; i++)
            cyc("cf", 1, 32'h0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 1, 1);
`ifdef IMEM_ARB_PERF_EN
        @(negedge clk);
        #1;
        check("perf_conf", perf_conflicts, 32'd5);
        check("perf_stall", perf_fetch_stalls, 32'd0);
`endif
        cyc("idle", 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        check("q_empty", f_q.size() + l_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Arbitrates the single-port instruction memory between the core fetch port and a program-loader/debug port.
- Sequences boot: after reset only the loader may access memory, and the core is held stalled until the loader signals boot completion.
- In run mode, grants are round-robin on conflict. The loader may lock the memory for multi-word bursts.
- Registers read data, so both requesters see a fixed 1-cycle response latency. Sits between the fetch stage, the loader, and the memory array.

Parameters:
- ADDR_W, 10, word-address width of the memory (depth 2**ADDR_W words).
- BOOT_BYPASS, 0, 1 = start in RUN after reset (no loader boot phase).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous active-low reset (0 = reset asserted).
- f_req  in  1  fetch request (read only).
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch granted this cycle.
- f_rvalid  out  1  fetch response valid, 1 cycle after f_gnt.
- f_rdata  out  32  fetch read data.
- f_err  out  1  with f_rvalid: misaligned or out-of-range address.
- l_req  in  1  loader request.
- l_we  in  1  loader write enable.
- l_lock  in  1  loader keeps ownership after grant while high.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader granted this cycle.
- l_rvalid  out  1  loader response valid (reads and writes), 1 cycle after l_gnt.
- l_rdata  out  32  loader read data (0 for writes).
- l_err  out  1  with l_rvalid: misaligned or out-of-range address.
- boot_done  in  1  loader pulse: boot image complete.
- core_stall  out  1  core must hold its PC.
- mem_addr  out  ADDR_W  word index to memory.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory combinational read data.

Behaviour:
- Reset (rst=0, asynchronous): state=BOOT (RUN if BOOT_BYPASS=1); core_stall=1 (0 if bypass). All gnt/rvalid/err=0, rdata=0, mem_we=0, mem_addr=0, rr_last=FETCH. In-flight responses are dropped.
- States: BOOT, RUN, LOCK.
  - BOOT: only the loader is granted (l_gnt=l_req); f_gnt=0; core_stall=1. boot_done=1 -> RUN next cycle; core_stall falls the same edge.
  - RUN: one request only -> grant it. Both requesting -> grant the one not in rr_last, then rr_last <= winner. Loader granted with l_lock=1 -> LOCK.
  - LOCK: l_gnt=l_req, f_gnt=0, core_stall=1. l_lock=0 -> RUN next cycle; fetch has priority in that first RUN cycle. boot_done is ignored outside BOOT.
- Grant is combinational from req and state. At most one gnt per cycle.
  - mem_addr = granted addr[ADDR_W+1:2]; mem_we = l_gnt & l_we & ~error.
- Error: addr[1:0]!=0 or addr[31:ADDR_W+2]!=0. No memory write; response has err=1, rdata=0.
- Response: on the cycle after a grant, rvalid=1 for one cycle; rdata = mem_rdata captured at the grant edge. Back-to-back grants give back-to-back rvalids.
- core_stall = (state!=RUN) | (f_req & ~f_gnt).
- Simultaneous l_lock drop and boot_done in BOOT: boot_done wins, go to RUN.

Optional Feature:
- Macro IMEM_ARB_PERF_EN.
- Defined: adds outputs perf_conflicts[31:0] (cycles with both requests high) and perf_fetch_stalls[31:0] (cycles with core_stall=1 in RUN/LOCK).
  - Saturating counters, cleared by reset.
- Undefined: no ports and no counter logic.

Decomposition:
- Package imem_arb_pkg holds:
  - state enum (BOOT/RUN/LOCK);
  - requester id enum (FETCH/LOADER) for rr_last;
  - ERR_RDATA=32'h0.
- One natural sub-module, imem_arb_rsp, handles response registering (rvalid/rdata/err per port), instantiated twice.

Test Plan:
- Boot load: reset, loader writes 0x0062E233 to 0x0 and 0x00832383 to 0x4, then pulses boot_done. f_req at 0x4 -> f_gnt next cycle, f_rvalid +1 with f_rdata=0x00832383; core_stall 1 until the boot_done edge.
- Contention: in RUN with f_req=l_req=1 for 4 cycles -> grants alternate L,F,L,F (rr_last=FETCH after reset); rvalids follow each grant by 1 cycle.
- Lock: loader takes a grant with l_lock=1, writes 3 words, then drops lock. f_gnt=0 and core_stall=1 throughout; the first RUN cycle grants fetch.
- Errors: f_addr=0x2 -> f_err=1, f_rdata=0. l_we to 0x1000 (ADDR_W=10) -> l_err=1, mem_we never asserted.
- Async reset mid-burst: drop rst between a grant and its response -> rvalid never pulses, state=BOOT, all outputs 0 immediately.
- With IMEM_ARB_PERF_EN: 5 conflict cycles -> perf_conflicts=5.
